// File: rtl/vga_timing_gen.sv
// Purpose : parametrised VGA raster timing (counters, syncs, DE, frame/line strobes).
// Latency : all outputs registered; hsync/vsync/de lag hcount/vcount by PIPE_DLY ce cycles.
// Flow    : no backpressure; ce low freezes every register, so all outputs hold.
// Ports   : pclk/rst_n/ce in; hcount/vcount position; hsync/vsync/de (delayed);
//           sof (strobe at 0,0) and sol (strobe at hcount 0), both undelayed.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int HCNT_W   = 10,
    parameter int VCNT_W   = 10,
    parameter int PIPE_DLY = 0
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              ce,
    output logic [HCNT_W-1:0] hcount,
    output logic [VCNT_W-1:0] vcount,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              sof,
    output logic              sol
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HCNT_W-1:0] H_LAST     = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_ACT_END  = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] H_SYNC_BEG = HCNT_W'(H_ACTIVE + H_FP);
    // Back porch of at least one pixel keeps this end bound inside the counter range.
    localparam logic [HCNT_W-1:0] H_SYNC_END = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VCNT_W-1:0] V_LAST     = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_ACT_END  = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] V_SYNC_BEG = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] V_SYNC_END = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON  = (H_POL != 0);
    localparam logic HS_OFF = ~HS_ON;
    localparam logic VS_ON  = (V_POL != 0);
    localparam logic VS_OFF = ~VS_ON;

    logic [HCNT_W-1:0] r_hcount;
    logic [VCNT_W-1:0] r_vcount;
    logic              r_sof;
    logic              r_sol;
    // Stage 0 holds the undelayed flag; stage PIPE_DLY is what leaves the block.
    logic [PIPE_DLY:0] r_de_sr;
    logic [PIPE_DLY:0] r_hs_sr;
    logic [PIPE_DLY:0] r_vs_sr;

    logic [HCNT_W-1:0] w_hcount_nxt;
    logic [VCNT_W-1:0] w_vcount_nxt;
    logic              w_de_nxt;
    logic              w_hs_nxt;
    logic              w_vs_nxt;

    // Flags are decoded from the next counter values so the registered flag
    // lines up with the registered counter it describes.
    always_comb begin
        w_hcount_nxt = r_hcount + HCNT_W'(1);
        w_vcount_nxt = r_vcount;
        if (r_hcount == H_LAST) begin
            w_hcount_nxt = '0;
            w_vcount_nxt = (r_vcount == V_LAST) ? '0 : r_vcount + VCNT_W'(1);
        end
        w_de_nxt = (w_hcount_nxt < H_ACT_END) && (w_vcount_nxt < V_ACT_END);
        w_hs_nxt = ((w_hcount_nxt >= H_SYNC_BEG) && (w_hcount_nxt < H_SYNC_END)) ? HS_ON : HS_OFF;
        w_vs_nxt = ((w_vcount_nxt >= V_SYNC_BEG) && (w_vcount_nxt < V_SYNC_END)) ? VS_ON : VS_OFF;
    end

    // Reset parks the counters on the last pixel of the frame so the first
    // enabled cycle lands on (0,0) with sof/sol raised.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcount <= H_LAST;
            r_vcount <= V_LAST;
            r_sof    <= 1'b0;
            r_sol    <= 1'b0;
            r_de_sr  <= '0;
            r_hs_sr  <= {(PIPE_DLY + 1){HS_OFF}};
            r_vs_sr  <= {(PIPE_DLY + 1){VS_OFF}};
        end else if (ce) begin
            r_hcount <= w_hcount_nxt;
            r_vcount <= w_vcount_nxt;
            r_sol    <= (w_hcount_nxt == '0);
            r_sof    <= (w_hcount_nxt == '0) && (w_vcount_nxt == '0);
            for (int i = PIPE_DLY; i > 0; i--) begin
                r_de_sr[i] <= r_de_sr[i-1];
                r_hs_sr[i] <= r_hs_sr[i-1];
                r_vs_sr[i] <= r_vs_sr[i-1];
            end
            r_de_sr[0] <= w_de_nxt;
            r_hs_sr[0] <= w_hs_nxt;
            r_vs_sr[0] <= w_vs_nxt;
        end
    end

    assign hcount = r_hcount;
    assign vcount = r_vcount;
    assign sof    = r_sof;
    assign sol    = r_sol;
    assign de     = r_de_sr[PIPE_DLY];
    assign hsync  = r_hs_sr[PIPE_DLY];
    assign vsync  = r_vs_sr[PIPE_DLY];

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, successor to the fixed 640x480 timing block. Produces pixel/line counters, sync pulses, a data-enable flag and frame/line start strobes for any mode set by parameters. Adds sync polarity parameters, a clock enable, and a configurable delay line that aligns sync/DE with a downstream pixel pipeline. Sits between the pixel clock domain root and the sprite/background renderers.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels, >=1)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines, >=1)
- H_POL, 0, hsync active level (0 negative, 1 positive)
- V_POL, 0, vsync active level
- HCNT_W, 10, hcount width; must hold H_TOTAL-1
- VCNT_W, 10, vcount width; must hold V_TOTAL-1
- PIPE_DLY, 0, extra cycles of delay on hsync/vsync/de (0..15)

Ports:
- pclk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; low freezes all state
- hcount  out  HCNT_W  pixel position in line
- vcount  out  VCNT_W  line position in frame
- hsync  out  1  horizontal sync, polarity H_POL, delayed PIPE_DLY
- vsync  out  1  vertical sync, polarity V_POL, delayed PIPE_DLY
- de  out  1  active video, high = visible pixel, delayed PIPE_DLY
- sof  out  1  one-cycle strobe at (hcount,vcount)=(0,0)
- sol  out  1  one-cycle strobe at hcount=0 (every line, incl. blanking)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- hcount increments on each ce cycle; at H_TOTAL-1 wraps to 0 and vcount advances; vcount wraps V_TOTAL-1 -> 0.
- Undelayed decode (from counter values held in the same cycle):
  - de_i = hcount<H_ACTIVE && vcount<V_ACTIVE
  - hsync_i active when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC
  - vsync_i active when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC; changes with vcount at the line boundary (hcount=0)
- All flags registered, computed from next-state counters; no combinational output paths.
- PIPE_DLY=0: hsync/vsync/de aligned with hcount/vcount. PIPE_DLY=N: they lag by N ce-qualified cycles through a shift register; sof/sol/hcount/vcount not delayed.
- ce low: counters, flags, strobes and delay line hold; a strobe high when ce drops stays high until next ce cycle.

## Timing
- Reset (rst_n low, async): hcount=H_TOTAL-1, vcount=V_TOTAL-1, hsync=~H_POL, vsync=~V_POL, de=0, sof=0, sol=0; delay line filled with inactive values.
- First ce cycle after reset release: hcount=0, vcount=0, de=1 (PIPE_DLY=0), sof=1, sol=1.
- Reset mid-frame: immediate return to reset values; restart identical to power-up.
- Line: H_TOTAL ce cycles; frame: H_TOTAL*V_TOTAL ce cycles.
- sof coincides with sol; sof one cycle per frame, sol one per line.
- Simultaneous h and v wrap at (H_TOTAL-1,V_TOTAL-1): both counters to 0 same edge.
- PIPE_DLY=N: delayed outputs after reset show inactive for N ce cycles, then follow the undelayed sequence.

## Test plan
- Reset/startup, defaults: hold rst_n low 5 cycles -> hcount=799, vcount=524, hsync=1, vsync=1, de=0; first ce edge -> (0,0), de=1, sof=1, sol=1.
- Line timing, defaults: de high hcount 0..639, hsync low exactly hcount 656..751 (96 cycles), line length 800 cycles, sol every 800 cycles.
- Frame timing, defaults: vsync low lines 490..491, de low lines 480..524, sof period 420000 cycles, vcount 524->0 together with hcount 799->0.
- ce gating: toggle ce 1/0 pseudo-randomly over one frame -> counters/outputs advance only on ce=1; sof period 420000 ce cycles; no output change while ce=0.
- 800x600 positive sync (H 800/40/128/88, V 600/1/4/23, H_POL=V_POL=1, HCNT_W=11): hsync high hcount 840..967, vsync high lines 601..604, totals 1056x628.
- PIPE_DLY=3, defaults: hsync/de/vsync equal undelayed reference shifted 3 ce cycles; de first rises 3 cycles after sof; reset mid-line clears delay line.
